// File: rtl/mapped_write_through_cache_pkg.sv
// Shared types and helpers for the direct-mapped write-through cache.
// CACHE_STATS_EN (optional macro) enables hit/miss counters in the top module.
package mapped_write_through_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    BYPASS_RD
  } cache_state_t;

  localparam logic [31:0] DEFAULT_UNCACHED_BASE = 32'h8000_0000;

  // Byte addresses are word-granular, so the tag covers addr[31:idx+2].
  function automatic int idx_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int num_lines);
    return 30 - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/mapped_write_through_cache_if.sv
// Core-side request bus plus external-memory port of one cache instance.
interface mapped_write_through_cache_if #(
  parameter int WORD_SIZE = 32
);

  logic [31:0]          addr;
  logic [WORD_SIZE-1:0] data_in;
  logic                 re;
  logic                 wr;
  logic [WORD_SIZE-1:0] data_out;
  logic                 ready;
  logic                 cacheable;
  logic [31:0]          ext_addr;
  logic [WORD_SIZE-1:0] ext_data_out;
  logic [WORD_SIZE-1:0] ext_data_in;
  logic                 ext_re;
  logic                 ext_wr;
  logic                 ext_ack;

  modport slave (
    input  addr, data_in, re, wr, ext_data_in, ext_ack,
    output data_out, ready, cacheable, ext_addr, ext_data_out, ext_re, ext_wr
  );

  modport master (
    output addr, data_in, re, wr, ext_data_in, ext_ack,
    input  data_out, ready, cacheable, ext_addr, ext_data_out, ext_re, ext_wr
  );

endinterface

// File: rtl/mapped_write_through_cache_mem_region_decode.sv
// Address-region decoder: RAM below UNCACHED_BASE is cacheable, MMIO above is not.
module mem_region_decode
  import mapped_write_through_cache_pkg::*;
#(
  parameter logic [31:0] UNCACHED_BASE = DEFAULT_UNCACHED_BASE
) (
  input  logic [31:0] addr,
  output logic        cacheable
);

  assign cacheable = (addr < UNCACHED_BASE);

endmodule

// File: rtl/mapped_write_through_cache.sv
// Direct-mapped, one-word-line, write-through, no-write-allocate cache with MMIO bypass.
// Define CACHE_STATS_EN to add hit_count/miss_count outputs.
module mapped_write_through_cache
  import mapped_write_through_cache_pkg::*;
#(
  parameter int          WORD_SIZE     = 32,
  parameter int          NUM_LINES     = 64,
  parameter logic [31:0] UNCACHED_BASE = DEFAULT_UNCACHED_BASE
) (
  input  logic                          clk,
  input  logic                          rst,
  mapped_write_through_cache_if.slave   bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count
`endif
);

  localparam int IDX   = idx_bits(NUM_LINES);
  localparam int TAG_W = tag_bits(NUM_LINES);

  logic [WORD_SIZE-1:0] line_data [NUM_LINES];
  logic [TAG_W-1:0]     line_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] line_valid;

  cache_state_t state_q, state_d;

  logic [IDX-1:0]       index;
  logic [TAG_W-1:0]     tag;
  logic                 hit;
  logic                 region_cacheable;
  logic [31:0]          aligned_addr;
  logic                 fill_en;
  logic                 write_en;
  logic                 ready;
  logic [WORD_SIZE-1:0] data_out;
  logic                 ext_re;
  logic                 ext_wr;
  logic [31:0]          ext_addr;
  logic [WORD_SIZE-1:0] ext_data_out;

  mem_region_decode #(
    .UNCACHED_BASE (UNCACHED_BASE)
  ) u_region (
    .addr      (bus.addr),
    .cacheable (region_cacheable)
  );

  assign index        = bus.addr[IDX+1:2];
  assign tag          = bus.addr[31:IDX+2];
  assign hit          = line_valid[index] && (line_tag[index] == tag);
  assign aligned_addr = {bus.addr[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ready        = 1'b0;
    data_out     = '0;
    ext_re       = 1'b0;
    ext_wr       = 1'b0;
    ext_addr     = '0;
    ext_data_out = '0;
    fill_en      = 1'b0;
    write_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.wr) begin
          state_d = WRITE;
        end else if (bus.re) begin
          if (region_cacheable && hit) begin
            ready    = 1'b1;
            data_out = line_data[index];
          end else if (region_cacheable) begin
            state_d = FILL;
          end else begin
            state_d = BYPASS_RD;
          end
        end else begin
          ready = 1'b1;
        end
      end
      FILL, BYPASS_RD: begin
        ext_re   = 1'b1;
        ext_addr = aligned_addr;
        if (bus.ext_ack) begin
          ready    = 1'b1;
          data_out = bus.ext_data_in;
          fill_en  = (state_q == FILL);
          state_d  = IDLE;
        end
      end
      WRITE: begin
        ext_wr       = 1'b1;
        ext_addr     = aligned_addr;
        ext_data_out = bus.data_in;
        if (bus.ext_ack) begin
          ready    = 1'b1;
          write_en = region_cacheable && hit;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line contents and tags deliberately have no reset; only valid bits do.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_data[index] <= bus.ext_data_in;
      line_tag[index]  <= tag;
    end else if (write_en) begin
      line_data[index] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid <= '0;
    end else if (fill_en) begin
      line_valid[index] <= 1'b1;
    end
  end

`ifdef CACHE_STATS_EN
  logic read_hit_done;

  assign read_hit_done = (state_q == IDLE) && bus.re && !bus.wr && region_cacheable && hit;

  // A completed fill is by construction a completed cacheable read miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (read_hit_done) hit_count <= hit_count + 32'd1;
      if (fill_en)       miss_count <= miss_count + 32'd1;
    end
  end
`endif

  assign bus.ready        = ready;
  assign bus.data_out     = data_out;
  assign bus.cacheable    = region_cacheable;
  assign bus.ext_re       = ext_re;
  assign bus.ext_wr       = ext_wr;
  assign bus.ext_addr     = ext_addr;
  assign bus.ext_data_out = ext_data_out;

endmodule

// File: tb/tb_mapped_write_through_cache.sv
// Self-checking bench: directed scenarios then random traffic against a line-map model.
module tb_mapped_write_through_cache;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mapped_write_through_cache_if #(.WORD_SIZE(32)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  mapped_write_through_cache dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: which word address each of the 64 lines holds, and its value.
  bit          m_valid [64];
  logic [29:0] m_waddr [64];
  logic [31:0] m_data  [64];
  int          m_hits   = 0;
  int          m_misses = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic is_wr, input logic also_re,
                                input logic [31:0] wd, input int delay, input logic [31:0] ext_rd);
    logic [29:0] wa;
    int          idx;
    bit          cach;
    bit          hit;
    wa   = a[31:2];
    idx  = int'(wa % 30'd64);
    cach = (a < 32'h8000_0000);
    hit  = cach && m_valid[idx] && (m_waddr[idx] == wa);
    bus.addr    = a;
    bus.data_in = wd;
    bus.wr      = is_wr;
    bus.re      = is_wr ? also_re : 1'b1;
    @(negedge clk);
    check_output("cacheable", 32'(bus.cacheable), 32'(cach));
    if (!is_wr && hit) begin
      check_output("hit_ready", 32'(bus.ready), 32'd1);
      check_output("hit_data", bus.data_out, m_data[idx]);
      check_output("hit_no_ext_re", 32'(bus.ext_re), 32'd0);
      m_hits++;
      @(posedge clk);
      #1;
    end else begin
      check_output("req_ready_low", 32'(bus.ready), 32'd0);
      check_output("idle_ext_strobes", {30'd0, bus.ext_re, bus.ext_wr}, 32'd0);
      @(posedge clk);
      #1;
      for (int d = 0; d < delay; d++) begin
        @(negedge clk);
        check_output("wait_ext_re", 32'(bus.ext_re), 32'(!is_wr));
        check_output("wait_ext_wr", 32'(bus.ext_wr), 32'(is_wr));
        check_output("wait_ext_addr", bus.ext_addr, {a[31:2], 2'b00});
        check_output("wait_ready_low", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1;
      end
      bus.ext_ack     = 1'b1;
      bus.ext_data_in = ext_rd;
      @(negedge clk);
      check_output("ack_ext_re", 32'(bus.ext_re), 32'(!is_wr));
      check_output("ack_ext_wr", 32'(bus.ext_wr), 32'(is_wr));
      check_output("ack_ext_addr", bus.ext_addr, {a[31:2], 2'b00});
      check_output("ack_ready", 32'(bus.ready), 32'd1);
      if (is_wr) check_output("ext_data_out", bus.ext_data_out, wd);
      else       check_output("ack_data_out", bus.data_out, ext_rd);
      @(posedge clk);
      #1;
      bus.ext_ack = 1'b0;
      if (!is_wr && cach) begin
        m_valid[idx] = 1'b1;
        m_waddr[idx] = wa;
        m_data[idx]  = ext_rd;
        m_misses++;
      end else if (is_wr && hit) begin
        m_data[idx] = wd;
      end
    end
    bus.re = 1'b0;
    bus.wr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input int delay, input logic [31:0] ext_rd);
    apply_stimulus(a, 1'b0, 1'b0, 32'h0, delay, ext_rd);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input int delay);
    apply_stimulus(a, 1'b1, 1'b0, wd, delay, $urandom);
  endtask

  initial begin
    logic [31:0] ra;
    rst             = 1'b1;
    bus.addr        = '0;
    bus.data_in     = '0;
    bus.re          = 1'b0;
    bus.wr          = 1'b0;
    bus.ext_ack     = 1'b0;
    bus.ext_data_in = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] idle checks after reset");
    @(negedge clk);
    check_output("idle_ready", 32'(bus.ready), 32'd1);
    check_output("idle_data_out", bus.data_out, 32'd0);
    check_output("idle_ext_addr", bus.ext_addr, 32'd0);
    check_output("idle_strobes", {30'd0, bus.ext_re, bus.ext_wr}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] cold read, hit, write-through");
    rd(32'h0000_0040, 3, 32'hDEAD_BEEF);
    rd(32'h0000_0040, 0, 32'h0);
    wr(32'h0000_0040, 32'h1234_5678, 1);
    rd(32'h0000_0040, 0, 32'h0);

    $display("[TB] write miss does not allocate");
    wr(32'h0000_0100, 32'hCAFE_F00D, 2);
    rd(32'h0000_0100, 0, 32'hCAFE_F00D);

    $display("[TB] conflicting lines");
    rd(32'h0000_0004, 1, 32'h0000_0A0A);
    rd(32'h0000_0104, 2, 32'h0000_0B0B);
    rd(32'h0000_0004, 0, 32'h0000_0C0C);

    $display("[TB] uncacheable bypass");
    rd(32'h8000_0010, 1, 32'h1111_2222);
    rd(32'h8000_0010, 2, 32'h3333_4444);
    rd(32'h0000_0004, 0, 32'h0);
    rd(32'h0000_0010, 0, 32'h5555_6666);

    $display("[TB] write has priority over read");
    apply_stimulus(32'h0000_0004, 1'b1, 1'b1, 32'hA5A5_5A5A, 1, 32'h0);
    rd(32'h0000_0004, 0, 32'h0);

    $display("[TB] ack while idle is ignored");
    bus.ext_ack     = 1'b1;
    bus.ext_data_in = 32'h7777_7777;
    @(negedge clk);
    check_output("idle_ack_ready", 32'(bus.ready), 32'd1);
    check_output("idle_ack_data", bus.data_out, 32'd0);
    @(posedge clk);
    #1 bus.ext_ack = 1'b0;
    rd(32'h0000_0080, 1, 32'h0808_0808);

    $display("[TB] reset during fill");
    bus.addr = 32'h0000_0200;
    bus.re   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("fill_before_rst", 32'(bus.ext_re), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_output("rst_ext_re", 32'(bus.ext_re), 32'd0);
    check_output("rst_data_out", bus.data_out, 32'd0);
    bus.re = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    rd(32'h0000_0040, 1, 32'h9999_0000);

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000 | ($urandom_range(0, 63) << 2);
      else                           ra = $urandom_range(0, 255) << 2;
      apply_stimulus(ra, ($urandom_range(0, 2) == 0), 1'($urandom), $urandom,
                     int'($urandom_range(0, 3)), $urandom);
    end

`ifdef CACHE_STATS_EN
    check_output("hit_count", hit_count, 32'(m_hits));
    check_output("miss_count", miss_count, 32'(m_misses));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
